// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/bubble/flush/redirect sequencing for the IF->ID->EX chain.
// Optional PIPE_CTRL_PERF_EN builds the stall and flush performance counters.
`default_nettype none

module pipe_ctrl #(
  parameter int MDIV_CYCLES = 34,
  parameter int CNT_W       = $clog2(MDIV_CYCLES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_src1_i,
  input  logic [4:0]  id_src2_i,
  input  logic [1:0]  id_src_use_i,
  input  logic        id_multi_i,
  input  logic        ex_valid_i,
  input  logic        ex_is_load_i,
  input  logic [4:0]  ex_dest_i,
  input  logic        mem_wait_i,
  input  logic        br_taken_i,
  input  logic [24:0] br_target_i,
  output logic        stall_if_o,
  output logic        stall_id_o,
  output logic        stall_ex_o,
  output logic        bubble_ex_o,
  output logic        flush_o,
  output logic        pc_load_o,
  output logic [24:0] pc_target_o,
  output logic        multi_busy_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_MULTI = 2'd1,
    S_MEMW  = 2'd2,
    S_REDIR = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(MDIV_CYCLES - 1);

  state_t            r_state, w_state_nxt, w_run_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_run_cnt;
  logic [24:0]       r_target, w_target_nxt, w_run_target;
  logic              w_luh;
  logic              w_run_stall_if, w_run_stall_id, w_run_stall_ex, w_run_bubble;
  logic              w_stall_if, w_stall_id, w_stall_ex, w_bubble;
  logic              w_flush, w_pc_load, w_busy;

  assign w_luh = ex_valid_i & ex_is_load_i & (ex_dest_i != 5'd0) & id_valid_i &
                 ((id_src_use_i[0] & (id_src1_i == ex_dest_i)) |
                  (id_src_use_i[1] & (id_src2_i == ex_dest_i)));

  // RUN decode is shared with the MEMW exit cycle.
  always_comb begin
    w_run_nxt      = S_RUN;
    w_run_cnt      = r_cnt;
    w_run_target   = r_target;
    w_run_stall_if = 1'b0;
    w_run_stall_id = 1'b0;
    w_run_stall_ex = 1'b0;
    w_run_bubble   = 1'b0;
    if (mem_wait_i) begin
      w_run_stall_if = 1'b1;
      w_run_stall_id = 1'b1;
      w_run_stall_ex = 1'b1;
      w_run_nxt      = S_MEMW;
    end else if (br_taken_i) begin
      w_run_target   = br_target_i;
      w_run_nxt      = S_REDIR;
    end else if (w_luh) begin
      w_run_stall_if = 1'b1;
      w_run_stall_id = 1'b1;
      w_run_bubble   = 1'b1;
    end else if (id_valid_i && id_multi_i) begin
      w_run_cnt      = c_CNT_LOAD;
      w_run_nxt      = S_MULTI;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_stall_if   = 1'b0;
    w_stall_id   = 1'b0;
    w_stall_ex   = 1'b0;
    w_bubble     = 1'b0;
    w_flush      = 1'b0;
    w_pc_load    = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_RUN: begin
        w_state_nxt  = w_run_nxt;
        w_cnt_nxt    = w_run_cnt;
        w_target_nxt = w_run_target;
        w_stall_if   = w_run_stall_if;
        w_stall_id   = w_run_stall_id;
        w_stall_ex   = w_run_stall_ex;
        w_bubble     = w_run_bubble;
      end
      S_MULTI: begin
        w_stall_if = 1'b1;
        w_stall_id = 1'b1;
        w_busy     = 1'b1;
        if (mem_wait_i) begin
          w_stall_ex = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_MEMW: begin
        if (mem_wait_i) begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_stall_ex = 1'b1;
        end else begin
          w_state_nxt  = w_run_nxt;
          w_cnt_nxt    = w_run_cnt;
          w_target_nxt = w_run_target;
          w_stall_if   = w_run_stall_if;
          w_stall_id   = w_run_stall_id;
          w_stall_ex   = w_run_stall_ex;
          w_bubble     = w_run_bubble;
        end
      end
      default: begin
        w_flush     = 1'b1;
        w_pc_load   = 1'b1;
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_cnt    <= '0;
      r_target <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_target <= w_target_nxt;
    end
  end

  assign stall_if_o   = w_stall_if & ~rst;
  assign stall_id_o   = w_stall_id & ~rst;
  assign stall_ex_o   = w_stall_ex & ~rst;
  assign bubble_ex_o  = w_bubble   & ~rst;
  assign flush_o      = w_flush    & ~rst;
  assign pc_load_o    = w_pc_load  & ~rst;
  assign multi_busy_o = w_busy     & ~rst;
  assign pc_target_o  = rst ? 25'd0 : r_target;
  assign state_o      = rst ? 2'd0  : r_state;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  // Flush count steps on REDIR entry so it is visible during the redirect cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_if && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if ((w_state_nxt == S_REDIR) && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = rst ? 32'd0 : r_stall_cnt;
  assign flush_cnt_o = rst ? 16'd0 : r_flush_cnt;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
`default_nettype none

module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i;
  logic [4:0]  id_src1_i, id_src2_i;
  logic [1:0]  id_src_use_i;
  logic        id_multi_i;
  logic        ex_valid_i, ex_is_load_i;
  logic [4:0]  ex_dest_i;
  logic        mem_wait_i, br_taken_i;
  logic [24:0] br_target_i;
  logic        stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, flush_o, pc_load_o;
  logic [24:0] pc_target_o;
  logic        multi_busy_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl #(.MDIV_CYCLES(34)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_src1_i(id_src1_i), .id_src2_i(id_src2_i),
    .id_src_use_i(id_src_use_i), .id_multi_i(id_multi_i),
    .ex_valid_i(ex_valid_i), .ex_is_load_i(ex_is_load_i), .ex_dest_i(ex_dest_i),
    .mem_wait_i(mem_wait_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o),
    .bubble_ex_o(bubble_ex_o), .flush_o(flush_o), .pc_load_o(pc_load_o),
    .pc_target_o(pc_target_o), .multi_busy_o(multi_busy_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid_i = 0; id_src1_i = 0; id_src2_i = 0; id_src_use_i = 0; id_multi_i = 0;
    ex_valid_i = 0; ex_is_load_i = 0; ex_dest_i = 0;
    mem_wait_i = 0; br_taken_i = 0; br_target_i = 0;
  endtask

  task automatic set_luh(input logic [4:0] dest);
    ex_valid_i = 1; ex_is_load_i = 1; ex_dest_i = dest;
    id_valid_i = 1; id_src2_i = dest; id_src_use_i = 2'b10;
  endtask

  // Packed view of all single-bit controls: {if,id,ex,bubble,flush,pc_load,busy}
  function automatic logic [31:0] ctl();
    return 32'({stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, flush_o, pc_load_o, multi_busy_o});
  endfunction

  initial begin
    int busy;
    int sx;
    idle_inputs();
    rst = 1;
    mem_wait_i = 1;
    #1;
    check("rst_ctl", ctl(), 0);
    check("rst_state", 32'(state_o), 0);
    step(); step();
    rst = 0;
    mem_wait_i = 0;
    #1;
    check("post_rst_ctl", ctl(), 0);
    check("post_rst_target", 32'(pc_target_o), 0);

    // Load-use via src2
    set_luh(5'd5);
    #1;
    check("luh_ctl", ctl(), 32'b1101000);
    check("luh_state", 32'(state_o), 0);
    step();
    idle_inputs();
    #1;
    check("luh_after_ctl", ctl(), 0);
    // dest r0 never interlocks
    set_luh(5'd0);
    #1;
    check("luh_r0_ctl", ctl(), 0);
    // src1 matches but its use bit is clear
    idle_inputs();
    ex_valid_i = 1; ex_is_load_i = 1; ex_dest_i = 5'd7;
    id_valid_i = 1; id_src1_i = 5'd7; id_src_use_i = 2'b10;
    #1;
    check("luh_nouse_ctl", ctl(), 0);
    idle_inputs();
    step();

    // Branch coinciding with load-use
    set_luh(5'd5);
    br_taken_i = 1; br_target_i = 25'h0000100;
    #1;
    check("br_luh_ctl", ctl(), 0);
    step();
    idle_inputs();
    #1;
    check("redir_state", 32'(state_o), 3);
    check("redir_ctl", ctl(), 32'b0000110);
    check("redir_target", 32'(pc_target_o), 32'h100);
`ifdef PIPE_CTRL_PERF_EN
    check("flush_cnt", 32'(flush_cnt_o), 1);
`else
    check("flush_cnt_tied", 32'(flush_cnt_o), 0);
`endif
    step();
    check("redir_exit_state", 32'(state_o), 0);
    check("redir_exit_ctl", ctl(), 0);
    check("target_hold", 32'(pc_target_o), 32'h100);

    // Multi-cycle issue, no waits
    id_valid_i = 1; id_multi_i = 1;
    #1;
    check("div_issue_ctl", ctl(), 0);
    step();
    idle_inputs();
    busy = 0; sx = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!multi_busy_o) break;
      busy++;
      if (state_o != 2'd1 || !stall_if_o || !stall_id_o || stall_ex_o) sx++;
      step();
    end
    check("div_busy_cycles", 32'(busy), 34);
    check("div_multi_ctl_errs", 32'(sx), 0);
    check("div_done_state", 32'(state_o), 0);

    // Multi-cycle with 3 wait cycles mid-op
    id_valid_i = 1; id_multi_i = 1;
    step();
    idle_inputs();
    busy = 0; sx = 0;
    for (int c = 0; c < 100; c++) begin
      mem_wait_i = (c >= 5 && c < 8);
      #1;
      if (!multi_busy_o) break;
      busy++;
      if (stall_ex_o) sx++;
      step();
    end
    mem_wait_i = 0;
    #1;
    check("divw_busy_cycles", 32'(busy), 37);
    check("divw_stall_ex_cycles", 32'(sx), 3);

    // MEMW with branch held
    mem_wait_i = 1; br_taken_i = 1; br_target_i = 25'h1ABCDE;
    #1;
    check("memw_enter_ctl", ctl(), 32'b1110000);
    step();
    check("memw_state", 32'(state_o), 2);
    check("memw_ctl", ctl(), 32'b1110000);
    step();
    check("memw_ctl2", ctl(), 32'b1110000);
    mem_wait_i = 0;
    #1;
    check("memw_exit_ctl", ctl(), 0);
    step();
    br_taken_i = 0;
    #1;
    check("memw_redir_ctl", ctl(), 32'b0000110);
    check("memw_redir_target", 32'(pc_target_o), 32'h1ABCDE);
    step();

    // Reset in cycle 10 of MULTI
    id_valid_i = 1; id_multi_i = 1;
    step();
    idle_inputs();
    for (int k = 0; k < 9; k++) step();
    check("pre_rst_busy", 32'(multi_busy_o), 1);
    rst = 1;
    #1;
    check("rst_mid_ctl", ctl(), 0);
    check("rst_mid_state", 32'(state_o), 0);
    step();
    rst = 0;
    #1;
    check("after_rst_state", 32'(state_o), 0);
    check("after_rst_ctl", ctl(), 0);
    check("after_rst_target", 32'(pc_target_o), 0);
    check("after_rst_stall_cnt", stall_cnt_o, 0);
    step();
    check("after_rst_state2", 32'(state_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
